// File: rtl/retire_trace_buffer.sv
// Retire-side trace monitor: captures architectural register writes into a FWFT FIFO,
// counts cycles/writes/stores, and raises done a fixed settle interval after ECALL.
//   state  | meaning
//   RUN    | program executing, capture and counting active
//   SETTLE | ECALL seen, in-flight instructions still retiring
//   DONE   | program complete, counters frozen, FIFO still drains
module retire_trace_buffer #(
  parameter int DEPTH         = 16,
  parameter int SETTLE_CYCLES = 5,
  parameter int CYC_TAG_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          debug_alu_result,
  input  logic [4:0]           debug_reg_addr,
  input  logic                 debug_reg_write,
  input  logic                 debug_mem_write,
  input  logic [31:0]          instr_d,
  output logic                 trace_valid,
  input  logic                 trace_ready,
  output logic [4:0]           trace_addr,
  output logic [31:0]          trace_result,
  output logic [CYC_TAG_W-1:0] trace_cycle,
  output logic [31:0]          cycle_count,
  output logic [15:0]          write_count,
  output logic [15:0]          store_count,
  output logic                 overflow,
  output logic                 done,
  output logic [1:0]           state
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = 5 + 32 + CYC_TAG_W;
  localparam logic [31:0] ECALL = 32'h0000_0073;

  typedef enum logic [1:0] {
    ST_RUN    = 2'b00,
    ST_SETTLE = 2'b01,
    ST_DONE   = 2'b10
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] settle_q, settle_d;

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    case (state_q)
      ST_RUN: begin
        if (instr_d == ECALL) begin
          state_d  = ST_SETTLE;
          settle_d = 8'(SETTLE_CYCLES);
        end
      end
      ST_SETTLE: begin
        // the edge that finds the counter at zero is the one that completes
        if (settle_q == 8'd0) state_d = ST_DONE;
        else                  settle_d = settle_q - 8'd1;
      end
      default: state_d = ST_DONE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_RUN;
      settle_q <= 8'd0;
      done     <= 1'b0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      done     <= (state_d == ST_DONE);
    end
  end

  assign state = state_q;

  logic active, capture, push, pop, full, empty;
  logic [AW:0]   wptr_q, rptr_q;
  logic [EW-1:0] mem [DEPTH];
  logic [EW-1:0] head;

  assign active  = (state_q != ST_DONE);
  assign capture = active && debug_reg_write && (debug_reg_addr != 5'd0);
  assign empty   = (wptr_q == rptr_q);
  assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign pop     = !empty && trace_ready;
  assign push    = capture && (!full || pop);

  always_ff @(posedge clk) begin
    if (push) mem[wptr_q[AW-1:0]] <= {debug_reg_addr, debug_alu_result, cycle_count[CYC_TAG_W-1:0]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      overflow    <= 1'b0;
      cycle_count <= 32'd0;
      write_count <= 16'd0;
      store_count <= 16'd0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      if (capture && !push) overflow <= 1'b1;
      if (active) cycle_count <= cycle_count + 32'd1;
      if (capture && write_count != 16'hFFFF) write_count <= write_count + 16'd1;
      if (active && debug_mem_write && store_count != 16'hFFFF) store_count <= store_count + 16'd1;
    end
  end

  assign head         = mem[rptr_q[AW-1:0]];
  assign trace_valid  = !empty;
  assign trace_addr   = empty ? 5'd0 : head[EW-1 -: 5];
  assign trace_result = empty ? 32'd0 : head[CYC_TAG_W +: 32];
  assign trace_cycle  = empty ? '0 : head[CYC_TAG_W-1:0];

endmodule

// File: tb/tb_retire_trace_buffer.sv
// Directed-plus-random bench for retire_trace_buffer against a queue/edge-count reference model.
module tb_retire_trace_buffer;
  localparam int DEPTH  = 16;
  localparam int SETTLE = 5;
  localparam int TW     = 16;
  localparam logic [31:0] ECALL = 32'h0000_0073;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [31:0]   debug_alu_result = '0;
  logic [4:0]    debug_reg_addr = '0;
  logic          debug_reg_write = 1'b0;
  logic          debug_mem_write = 1'b0;
  logic [31:0]   instr_d = '0;
  logic          trace_ready = 1'b0;
  logic          trace_valid;
  logic [4:0]    trace_addr;
  logic [31:0]   trace_result;
  logic [TW-1:0] trace_cycle;
  logic [31:0]   cycle_count;
  logic [15:0]   write_count, store_count;
  logic          overflow, done;
  logic [1:0]    state;

  retire_trace_buffer #(.DEPTH(DEPTH), .SETTLE_CYCLES(SETTLE), .CYC_TAG_W(TW)) dut (
    .clk(clk), .rst(rst),
    .debug_alu_result(debug_alu_result), .debug_reg_addr(debug_reg_addr),
    .debug_reg_write(debug_reg_write), .debug_mem_write(debug_mem_write),
    .instr_d(instr_d),
    .trace_valid(trace_valid), .trace_ready(trace_ready),
    .trace_addr(trace_addr), .trace_result(trace_result), .trace_cycle(trace_cycle),
    .cycle_count(cycle_count), .write_count(write_count), .store_count(store_count),
    .overflow(overflow), .done(done), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]    a;
    logic [31:0]   r;
    logic [TW-1:0] t;
  } ent_t;

  ent_t        m_q[$];
  logic [31:0] m_cyc;
  int          m_wc, m_sc, m_e, m_ecall;
  bit          m_ovf, m_done;
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic model_reset();
    m_q.delete();
    m_cyc = 0; m_wc = 0; m_sc = 0; m_e = 0; m_ecall = -1;
    m_ovf = 0; m_done = 0;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [1:0] st;
    st = m_done ? 2'b10 : (m_ecall >= 0 ? 2'b01 : 2'b00);
    chk("trace_valid", 64'(trace_valid), 64'(m_q.size() != 0));
    if (m_q.size() != 0) begin
      chk("trace_addr", 64'(trace_addr), 64'(m_q[0].a));
      chk("trace_result", 64'(trace_result), 64'(m_q[0].r));
      chk("trace_cycle", 64'(trace_cycle), 64'(m_q[0].t));
    end else begin
      chk("trace_addr_empty", 64'(trace_addr), 64'd0);
      chk("trace_result_empty", 64'(trace_result), 64'd0);
      chk("trace_cycle_empty", 64'(trace_cycle), 64'd0);
    end
    chk("cycle_count", 64'(cycle_count), 64'(m_cyc));
    chk("write_count", 64'(write_count), 64'(m_wc));
    chk("store_count", 64'(store_count), 64'(m_sc));
    chk("overflow", 64'(overflow), 64'(m_ovf));
    chk("done", 64'(done), 64'(m_done));
    chk("state", 64'(state), 64'(st));
  endtask

  task automatic step(input logic wr, input logic [4:0] a, input logic [31:0] r,
                      input logic mw, input logic [31:0] ins, input logic rdy);
    bit act;
    debug_reg_write = wr; debug_reg_addr = a; debug_alu_result = r;
    debug_mem_write = mw; instr_d = ins; trace_ready = rdy;
    act = !m_done;
    if (m_q.size() != 0 && rdy) void'(m_q.pop_front());
    if (act && wr && a != 5'd0) begin
      if (m_q.size() < DEPTH) m_q.push_back('{a, r, m_cyc[TW-1:0]});
      else m_ovf = 1;
      if (m_wc < 65535) m_wc++;
    end
    if (act && mw && m_sc < 65535) m_sc++;
    if (act && m_ecall < 0 && ins == ECALL) m_ecall = m_e + 1;
    if (act) m_cyc++;
    m_e++;
    if (m_ecall >= 0 && m_e == m_ecall + SETTLE + 1) m_done = 1;
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic rand_step(input bit allow_ecall);
    logic [31:0] ins;
    ins = $urandom;
    if (allow_ecall && $urandom_range(0, 7) == 0) ins = ECALL;
    if (!allow_ecall && ins == ECALL) ins = 32'd0;
    step(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
         1'($urandom_range(0, 1)), ins, 1'($urandom_range(0, 3) == 0));
  endtask

  initial begin
    model_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 check_all();
    @(negedge clk) rst = 1'b0;

    // three writes to x12 with the consumer stalled, then drain
    step(0, 0, 0, 0, 0, 0);
    repeat (3) step(1, 5'd12, 32'h0001_0000, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    repeat (3) step(0, 0, 0, 0, 0, 1);

    // x0 writes are invisible
    step(1, 5'd0, 32'hDEAD_BEEF, 0, 0, 1);
    step(0, 0, 0, 1, 0, 0);

    // overflow, then push and pop together while full
    for (int i = 0; i < 18; i++) step(1, 5'(1 + i), 32'h1000 + i, 0, 0, 0);
    step(1, 5'd7, 32'hCAFE_0001, 0, 0, 1);
    step(1, 5'd8, 32'hCAFE_0002, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);

    for (int i = 0; i < 150; i++) rand_step(1'b0);

    // ECALL, capture during SETTLE, second ECALL ignored
    step(0, 0, 0, 0, ECALL, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    step(1, 5'd13, 32'd5, 0, 0, 0);
    step(0, 0, 0, 0, ECALL, 1);
    for (int i = 0; i < 4; i++) rand_step(1'b1);
    for (int i = 0; i < 6; i++) step(1, 5'd9, $urandom, 1, ECALL, 1'($urandom_range(0, 1)));
    repeat (20) step(0, 0, 0, 0, 0, 1);

    // reset asserted mid-SETTLE with four entries queued
    rst = 1'b1;
    model_reset();
    #1 check_all();
    @(negedge clk) rst = 1'b0;
    for (int i = 0; i < 4; i++) step(1, 5'(20 + i), $urandom, 0, 0, 0);
    step(0, 0, 0, 0, ECALL, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    #2 rst = 1'b1;
    model_reset();
    #1 check_all();
    @(negedge clk) rst = 1'b0;
    for (int i = 0; i < 40; i++) rand_step(1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
